// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared MIPS datapath types and defaults
// Purpose: register-file defaults, clear-FSM state type and the zero-register address.
// Ports: none (package).
package mips_pkg;

  localparam int REG_DATA_W   = 32;
  localparam int REG_DEPTH    = 32;
  localparam int RF_ZERO_ADDR = 0;

  typedef enum logic {
    RF_CLEAR = 1'b0,
    RF_RUN   = 1'b1
  } rf_state_t;

endpackage

// File: rtl/regfile_clear_fsm.sv
// rtl/regfile_clear_fsm.sv - post-reset clear sequencer for the register file
// Purpose: after rst, walks clr_addr over every register (one per cycle) and then
//          enters RUN; ready is a flop that rises together with the RUN state.
// Ports:
//   clk       in   rising-edge clock
//   rst       in   synchronous active-high reset; restarts the clear from address 0
//   clr_we    out  1 while clearing: zero the word at clr_addr this cycle
//   clr_addr  out  ADDR_W  word being cleared
//   run       out  1 once clearing is done (user reads/writes allowed)
//   ready     out  registered ready flag for the decode stage
module regfile_clear_fsm
  import mips_pkg::*;
#(
  parameter  int DEPTH  = REG_DEPTH,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr,
  output logic              run,
  output logic              ready
);

  rf_state_t         state_q;
  logic [ADDR_W-1:0] clr_cnt_q;
  logic              ready_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= RF_CLEAR;
      clr_cnt_q <= '0;
      ready_q   <= 1'b0;
    end else begin
      case (state_q)
        RF_CLEAR: begin
          // Counter wraps to 0 after the last word; harmless since RUN ignores it.
          clr_cnt_q <= clr_cnt_q + 1'b1;
          if (clr_cnt_q == ADDR_W'(DEPTH - 1)) begin
            state_q <= RF_RUN;
            ready_q <= 1'b1;
          end
        end
        RF_RUN: begin
          state_q <= RF_RUN;
        end
        default: begin
          state_q <= RF_CLEAR;
        end
      endcase
    end
  end

  assign clr_we   = (state_q == RF_CLEAR);
  assign clr_addr = clr_cnt_q;
  assign run      = (state_q == RF_RUN);
  assign ready    = ready_q;

endmodule

// File: rtl/regfile_multiport.sv
// rtl/regfile_multiport.sv - parametrised multi-read-port MIPS register file
// Purpose: DEPTH x DATA_W flop array, one synchronous write port, NUM_RD registered
//          read ports, optional hardwired-zero register 0 and write-to-read bypass,
//          cleared to zero by a sequencer after every reset.
// Ports:
//   clk      in   rising-edge clock
//   rst      in   synchronous active-high reset
//   wr_en    in   write strobe
//   wr_addr  in   ADDR_W write address
//   wr_data  in   DATA_W write data
//   rd_addr  in   NUM_RD*ADDR_W read addresses, port p at [p*ADDR_W +: ADDR_W]
//   rd_data  out  NUM_RD*DATA_W registered read data, port p at [p*DATA_W +: DATA_W]
//   ready    out  1 once the clear sequence has completed
module regfile_multiport
  import mips_pkg::*;
#(
  parameter  int DATA_W   = REG_DATA_W,
  parameter  int DEPTH    = REG_DEPTH,
  parameter  int NUM_RD   = 2,
  parameter  int ZERO_REG = 1,
  parameter  int BYPASS   = 1,
  localparam int ADDR_W   = $clog2(DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic                     ready
);

  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;
  logic              run;
  logic              wr_zero_hit;
  logic              user_we;

  logic [DATA_W-1:0] mem_q [DEPTH];

  regfile_clear_fsm #(
    .DEPTH (DEPTH)
  ) u_clear_fsm (
    .clk      (clk),
    .rst      (rst),
    .clr_we   (clr_we),
    .clr_addr (clr_addr),
    .run      (run),
    .ready    (ready)
  );

  // User writes are accepted only in RUN and never in a reset cycle; writes to
  // the hardwired-zero register are dropped here so bypass sees them dropped too.
  assign wr_zero_hit = (ZERO_REG != 0) && (wr_addr == ADDR_W'(RF_ZERO_ADDR));
  assign user_we     = run && !rst && wr_en && !wr_zero_hit;

  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem_q[clr_addr] <= '0;
    end else if (user_we) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic              rd_zero_hit;
    logic              byp_hit;
    logic [DATA_W-1:0] rd_q;

    assign ra          = rd_addr[p*ADDR_W +: ADDR_W];
    assign rd_zero_hit = (ZERO_REG != 0) && (ra == ADDR_W'(RF_ZERO_ADDR));
    assign byp_hit     = (BYPASS != 0) && user_we && (wr_addr == ra);

    // Zero rule outranks bypass; outputs stay 0 for the whole clear.
    always_ff @(posedge clk) begin
      if (rst || !run) begin
        rd_q <= '0;
      end else if (rd_zero_hit) begin
        rd_q <= '0;
      end else if (byp_hit) begin
        rd_q <= wr_data;
      end else begin
        rd_q <= mem_q[ra];
      end
    end

    assign rd_data[p*DATA_W +: DATA_W] = rd_q;
  end

endmodule

// File: tb/tb_regfile_multiport.sv
// tb/tb_regfile_multiport.sv - directed self-checking bench for regfile_multiport
module tb_regfile_multiport;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Instance A: defaults (32x32, 2 read ports, zero reg, bypass)
  logic        a_rst = 1'b1;
  logic        a_wr_en = 1'b0;
  logic [4:0]  a_wr_addr = '0;
  logic [31:0] a_wr_data = '0;
  logic [9:0]  a_rd_addr = '0;
  logic [63:0] a_rd_data;
  logic        a_ready;

  // Instance B: 16-bit, 8 deep, 3 read ports, ordinary r0, no bypass
  logic        b_rst = 1'b1;
  logic        b_wr_en = 1'b0;
  logic [2:0]  b_wr_addr = '0;
  logic [15:0] b_wr_data = '0;
  logic [8:0]  b_rd_addr = '0;
  logic [47:0] b_rd_data;
  logic        b_ready;

  regfile_multiport u_a (
    .clk     (clk),
    .rst     (a_rst),
    .wr_en   (a_wr_en),
    .wr_addr (a_wr_addr),
    .wr_data (a_wr_data),
    .rd_addr (a_rd_addr),
    .rd_data (a_rd_data),
    .ready   (a_ready)
  );

  regfile_multiport #(
    .DATA_W   (16),
    .DEPTH    (8),
    .NUM_RD   (3),
    .ZERO_REG (0),
    .BYPASS   (0)
  ) u_b (
    .clk     (clk),
    .rst     (b_rst),
    .wr_en   (b_wr_en),
    .wr_addr (b_wr_addr),
    .wr_data (b_wr_data),
    .rd_addr (b_rd_addr),
    .rd_data (b_rd_data),
    .ready   (b_ready)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic a_write(input logic [4:0] addr, input logic [31:0] data);
    a_wr_en = 1'b1;
    a_wr_addr = addr;
    a_wr_data = data;
    tick();
    a_wr_en = 1'b0;
  endtask

  task automatic b_write(input logic [2:0] addr, input logic [15:0] data);
    b_wr_en = 1'b1;
    b_wr_addr = addr;
    b_wr_data = data;
    tick();
    b_wr_en = 1'b0;
  endtask

  // Cycles from the current point until ready is seen high (bounded).
  task automatic a_wait_ready(output int n);
    n = 0;
    while (!a_ready && n < 200) begin
      tick();
      n++;
    end
  endtask

  task automatic b_wait_ready(output int n);
    n = 0;
    while (!b_ready && n < 200) begin
      tick();
      n++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;

    // ---------------- instance A ----------------
    tick();
    chk("A reset ready", 64'(a_ready), 64'd0);
    chk("A reset rd_data", a_rd_data, 64'd0);
    a_rst = 1'b0;
    a_wait_ready(n);
    chk("A first clear length", 64'(n), 64'd32);

    // T1: preload, pulse rst, expect 32 cycles of !ready, then all zero
    a_write(5'd1, 32'h1111_1111);
    a_write(5'd2, 32'h2222_2222);
    a_write(5'd31, 32'h3131_3131);
    a_rd_addr = {5'd1, 5'd2};
    tick();
    chk("T1 preload r2", 64'(a_rd_data[31:0]), 64'h2222_2222);
    chk("T1 preload r1", 64'(a_rd_data[63:32]), 64'h1111_1111);
    a_rst = 1'b1;
    tick();
    a_rst = 1'b0;
    chk("T1 rst ready", 64'(a_ready), 64'd0);
    chk("T1 rst rd_data", a_rd_data, 64'd0);
    a_wait_ready(n);
    chk("T1 clear length", 64'(n), 64'd32);
    for (int a = 0; a < 32; a += 2) begin
      a_rd_addr = {5'(a + 1), 5'(a)};
      tick();
      chk($sformatf("T1 clr r%0d", a), 64'(a_rd_data[31:0]), 64'd0);
      chk($sformatf("T1 clr r%0d", a + 1), 64'(a_rd_data[63:32]), 64'd0);
    end

    // T2: write r5, read it on port 1
    a_write(5'd5, 32'hDEAD_BEEF);
    a_rd_addr = {5'd5, 5'd2};
    tick();
    chk("T2 r5 port1", 64'(a_rd_data[63:32]), 64'hDEAD_BEEF);
    chk("T2 r2 port0", 64'(a_rd_data[31:0]), 64'd0);

    // T3: r0 is hardwired zero
    a_write(5'd0, 32'h1234_5678);
    a_rd_addr = {5'd0, 5'd0};
    tick();
    chk("T3 r0 both ports", a_rd_data, 64'd0);

    // T4: same-cycle write/read of r7 is bypassed
    a_write(5'd7, 32'h0000_0001);
    a_wr_en = 1'b1;
    a_wr_addr = 5'd7;
    a_wr_data = 32'hA5A5_A5A5;
    a_rd_addr = {5'd7, 5'd7};
    tick();
    a_wr_en = 1'b0;
    chk("T4 bypass both ports", a_rd_data, 64'hA5A5_A5A5_A5A5_A5A5);

    // T5: write at clear cycle 4 is dropped
    a_rst = 1'b1;
    tick();
    a_rst = 1'b0;
    repeat (4) tick();
    a_write(5'd3, 32'h0000_00FF);
    a_wait_ready(n);
    chk("T5 ready reached", 64'(a_ready), 64'd1);
    a_rd_addr = {5'd3, 5'd3};
    tick();
    chk("T5 r3 after clear", a_rd_data, 64'd0);

    // T6: rst in RUN zeroes outputs and drops the write; rst again mid-clear
    a_write(5'd20, 32'h2020_2020);
    a_rd_addr = {5'd20, 5'd20};
    a_rst = 1'b1;
    a_wr_en = 1'b1;
    a_wr_addr = 5'd21;
    a_wr_data = 32'h2121_2121;
    tick();
    a_wr_en = 1'b0;
    a_rst = 1'b0;
    chk("T6 rst in run rd_data", a_rd_data, 64'd0);
    repeat (10) tick();
    a_rst = 1'b1;
    tick();
    a_rst = 1'b0;
    a_wait_ready(n);
    chk("T6 clear length after re-rst", 64'(n), 64'd32);
    a_rd_addr = {5'd21, 5'd20};
    tick();
    chk("T6 r20/r21 zero", a_rd_data, 64'd0);

    // ---------------- instance B ----------------
    tick();
    b_rst = 1'b0;
    b_wait_ready(n);
    chk("B first clear length", 64'(n), 64'd8);

    b_write(3'd3, 16'h3333);
    b_write(3'd6, 16'h6666);
    b_rst = 1'b1;
    tick();
    b_rst = 1'b0;
    chk("B1 rst ready", 64'(b_ready), 64'd0);
    b_wait_ready(n);
    chk("B1 clear length", 64'(n), 64'd8);
    b_rd_addr = {3'd2, 3'd1, 3'd0};
    tick();
    chk("B1 r0-r2 zero", 64'(b_rd_data), 64'd0);
    b_rd_addr = {3'd5, 3'd4, 3'd3};
    tick();
    chk("B1 r3-r5 zero", 64'(b_rd_data), 64'd0);
    b_rd_addr = {3'd7, 3'd6, 3'd6};
    tick();
    chk("B1 r6-r7 zero", 64'(b_rd_data), 64'd0);

    b_write(3'd5, 16'hBEEF);
    b_rd_addr = {3'd0, 3'd5, 3'd0};
    tick();
    chk("B2 r5 port1", 64'(b_rd_data[31:16]), 64'h0000_BEEF);

    b_write(3'd0, 16'h5678);
    b_rd_addr = {3'd0, 3'd0, 3'd0};
    tick();
    chk("B3 r0 ordinary", 64'(b_rd_data), 64'h5678_5678_5678);

    b_write(3'd7, 16'h0001);
    b_wr_en = 1'b1;
    b_wr_addr = 3'd7;
    b_wr_data = 16'hA5A5;
    b_rd_addr = {3'd7, 3'd7, 3'd7};
    tick();
    b_wr_en = 1'b0;
    chk("B4 no bypass old word", 64'(b_rd_data), 64'h0001_0001_0001);
    tick();
    chk("B4 new word next cycle", 64'(b_rd_data), 64'hA5A5_A5A5_A5A5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
